// File: rtl/imem_boot_loader.sv
// Instruction memory for the 10-bit teaching CPU: a program is streamed in at boot
// over a valid/ready port, then served to fetch with a registered one-cycle read.
module imem_boot_loader #(
  parameter int                DATA_W    = 10,
  parameter int                ADDR_W    = 10,
  parameter logic [DATA_W-1:0] FILL_WORD = 10'b0010000010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              overflow,
  output logic              run,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              addr_err
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                read_valid_q, read_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  // The write pointer and load_count always move together and stop at DEPTH,
  // so a single counter serves as both.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    overflow_d   = overflow_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
        end
      end

      LOAD: begin
        if (load_start) begin
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
        end else if (load_valid) begin
          if (wr_ptr_q < DEPTH_C) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (load_last) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // A reload wins over a fetch issued in the same cycle.
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
        end else if (fetch_en) begin
          read_valid_d = 1'b1;
          if ({1'b0, fetch_addr} < wr_ptr_q) begin
            read_data_d = mem[fetch_addr];
          end else begin
            read_data_d = FILL_WORD;
            addr_err_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      overflow_q   <= overflow_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Storage is deliberately left out of reset so a program survives a CPU reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= load_data;
    end
  end

  assign load_ready = (state_q == LOAD);
  assign run        = (state_q == RUN);
  assign load_count = wr_ptr_q;
  assign overflow   = overflow_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a vector table drives the default-size
// instance, hand sequences cover async reset and overflow on a 4-word instance.
module tb_imem_boot_loader;

  localparam logic [9:0] FILL = 10'b0010000010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // default-size instance
  logic        load_start = 0, load_valid = 0, load_last = 0, fetch_en = 0;
  logic [9:0]  load_data = '0, fetch_addr = '0;
  logic        load_ready, overflow, run, read_valid, addr_err;
  logic [10:0] load_count;
  logic [9:0]  read_data;

  // 4-word instance for overflow / exact-full cases
  logic        s_load_start = 0, s_load_valid = 0, s_load_last = 0, s_fetch_en = 0;
  logic [9:0]  s_load_data = '0;
  logic [1:0]  s_fetch_addr = '0;
  logic        s_load_ready, s_overflow, s_run, s_read_valid, s_addr_err;
  logic [2:0]  s_load_count;
  logic [9:0]  s_read_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_count(load_count),
    .overflow(overflow), .run(run), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .read_data(read_data), .read_valid(read_valid), .addr_err(addr_err)
  );

  imem_boot_loader #(.DATA_W(10), .ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .load_start(s_load_start), .load_valid(s_load_valid), .load_data(s_load_data),
    .load_last(s_load_last), .load_ready(s_load_ready), .load_count(s_load_count),
    .overflow(s_overflow), .run(s_run), .fetch_en(s_fetch_en), .fetch_addr(s_fetch_addr),
    .read_data(s_read_data), .read_valid(s_read_valid), .addr_err(s_addr_err)
  );

  typedef struct {
    logic        ls;
    logic        lv;
    logic [9:0]  ld;
    logic        ll;
    logic        fe;
    logic [9:0]  fa;
    logic        rv;
    logic [9:0]  rd;
    logic        err;
    logic [10:0] cnt;
    logic        run;
    logic        rdy;
    logic        ovf;
  } vec_t;

  vec_t vecs[23];

  // Compare one value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, then settle just after the next rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    load_start = v.ls; load_valid = v.lv; load_data = v.ld; load_last = v.ll;
    fetch_en = v.fe; fetch_addr = v.fa;
    @(posedge clk);
    #1;
  endtask

  task automatic smallStep(input logic ls, input logic lv, input logic [9:0] ld,
                           input logic ll, input logic fe, input logic [1:0] fa);
    @(negedge clk);
    s_load_start = ls; s_load_valid = lv; s_load_data = ld; s_load_last = ll;
    s_fetch_en = fe; s_fetch_addr = fa;
    @(posedge clk);
    #1;
  endtask

  task automatic checkBig(input int idx, input vec_t v);
    checkOutput("read_valid", idx, 32'(read_valid), 32'(v.rv));
    checkOutput("read_data",  idx, 32'(read_data),  32'(v.rd));
    checkOutput("addr_err",   idx, 32'(addr_err),   32'(v.err));
    checkOutput("load_count", idx, 32'(load_count), 32'(v.cnt));
    checkOutput("run",        idx, 32'(run),        32'(v.run));
    checkOutput("load_ready", idx, 32'(load_ready), 32'(v.rdy));
    checkOutput("overflow",   idx, 32'(overflow),   32'(v.ovf));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //            ls lv ld            ll fe fa    | rv rd            err cnt run rdy ovf
    vecs[0]  = '{0, 0, 10'd0,         0, 1, 10'd0,  0, 10'd0,         0, 11'd0, 0, 0, 0};
    vecs[1]  = '{1, 0, 10'd0,         0, 0, 10'd0,  0, 10'd0,         0, 11'd0, 0, 1, 0};
    vecs[2]  = '{0, 1, 10'b1100110100,0, 0, 10'd0,  0, 10'd0,         0, 11'd1, 0, 1, 0};
    vecs[3]  = '{0, 1, 10'b1100111101,0, 0, 10'd0,  0, 10'd0,         0, 11'd2, 0, 1, 0};
    vecs[4]  = '{0, 0, 10'b1111111111,0, 0, 10'd0,  0, 10'd0,         0, 11'd2, 0, 1, 0};
    vecs[5]  = '{0, 1, 10'b0000000000,0, 0, 10'd0,  0, 10'd0,         0, 11'd3, 0, 1, 0};
    vecs[6]  = '{0, 1, 10'b1101000100,1, 0, 10'd0,  0, 10'd0,         0, 11'd4, 1, 0, 0};
    vecs[7]  = '{0, 0, 10'd0,         0, 1, 10'd0,  1, 10'b1100110100,0, 11'd4, 1, 0, 0};
    vecs[8]  = '{0, 0, 10'd0,         0, 1, 10'd1,  1, 10'b1100111101,0, 11'd4, 1, 0, 0};
    vecs[9]  = '{0, 0, 10'd0,         0, 1, 10'd2,  1, 10'b0000000000,0, 11'd4, 1, 0, 0};
    vecs[10] = '{0, 0, 10'd0,         0, 1, 10'd3,  1, 10'b1101000100,0, 11'd4, 1, 0, 0};
    vecs[11] = '{0, 0, 10'd0,         0, 1, 10'd4,  1, FILL,          1, 11'd4, 1, 0, 0};
    vecs[12] = '{0, 0, 10'd0,         0, 1, 10'd1023,1, FILL,         1, 11'd4, 1, 0, 0};
    vecs[13] = '{0, 0, 10'd0,         0, 0, 10'd2,  0, FILL,          0, 11'd4, 1, 0, 0};
    vecs[14] = '{0, 0, 10'd0,         0, 1, 10'd1,  1, 10'b1100111101,0, 11'd4, 1, 0, 0};
    vecs[15] = '{1, 0, 10'd0,         0, 1, 10'd0,  0, 10'b1100111101,0, 11'd0, 0, 1, 0};
    vecs[16] = '{0, 1, 10'b0101010101,0, 0, 10'd0,  0, 10'b1100111101,0, 11'd1, 0, 1, 0};
    vecs[17] = '{1, 1, 10'b1111111111,1, 0, 10'd0,  0, 10'b1100111101,0, 11'd0, 0, 1, 0};
    vecs[18] = '{0, 1, 10'b0011001100,0, 0, 10'd0,  0, 10'b1100111101,0, 11'd1, 0, 1, 0};
    vecs[19] = '{0, 1, 10'b0000011111,1, 0, 10'd0,  0, 10'b1100111101,0, 11'd2, 1, 0, 0};
    vecs[20] = '{0, 0, 10'd0,         0, 1, 10'd0,  1, 10'b0011001100,0, 11'd2, 1, 0, 0};
    vecs[21] = '{0, 0, 10'd0,         0, 1, 10'd1,  1, 10'b0000011111,0, 11'd2, 1, 0, 0};
    vecs[22] = '{0, 0, 10'd0,         0, 1, 10'd2,  1, FILL,          1, 11'd2, 1, 0, 0};

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_read_valid", -1, 32'(read_valid), 0);
    checkOutput("reset_run",        -1, 32'(run),        0);
    checkOutput("reset_load_ready", -1, 32'(load_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main load / fetch / reload sequence
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      checkBig(i, vecs[i]);
    end

    // Async reset asserted mid-cycle while a fetch is in flight
    @(negedge clk);
    load_start = 0; load_valid = 0; load_last = 0; fetch_en = 1; fetch_addr = 10'd0;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_read_valid", 100, 32'(read_valid), 1);
    checkOutput("pre_reset_read_data",  100, 32'(read_data), 32'(10'b0011001100));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_read_valid", 101, 32'(read_valid), 0);
    checkOutput("async_read_data",  101, 32'(read_data),  0);
    checkOutput("async_run",        101, 32'(run),        0);
    checkOutput("async_load_count", 101, 32'(load_count), 0);
    checkOutput("async_addr_err",   101, 32'(addr_err),   0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("post_reset_read_valid", 102 + i, 32'(read_valid), 0);
      checkOutput("post_reset_run",        102 + i, 32'(run),        0);
    end
    @(negedge clk);
    fetch_en = 0;

    // Overflow on the 4-word instance: fifth word dropped, still enters RUN
    smallStep(1, 0, 10'd0, 0, 0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      smallStep(0, 1, (i == 4) ? 10'b1111111111 : 10'(i + 1), (i == 4), 0, 2'd0);
      checkOutput("small_count",    200 + i, 32'(s_load_count), (i < 4) ? i + 1 : 4);
      checkOutput("small_overflow", 200 + i, 32'(s_overflow),   (i == 4) ? 1 : 0);
    end
    checkOutput("small_run", 205, 32'(s_run), 1);
    for (int i = 0; i < 4; i++) begin
      smallStep(0, 0, 10'd0, 0, 1, 2'(i));
      checkOutput("small_read_data",  210 + i, 32'(s_read_data), i + 1);
      checkOutput("small_read_valid", 210 + i, 32'(s_read_valid), 1);
      checkOutput("small_addr_err",   210 + i, 32'(s_addr_err), 0);
    end

    // Reload clears overflow; exactly DEPTH words loads without overflow
    smallStep(1, 0, 10'd0, 0, 0, 2'd0);
    checkOutput("small_reload_overflow", 220, 32'(s_overflow), 0);
    checkOutput("small_reload_count",    220, 32'(s_load_count), 0);
    for (int i = 0; i < 4; i++) begin
      smallStep(0, 1, 10'(10'b1010000000 + i), (i == 3), 0, 2'd0);
    end
    checkOutput("full_count",    221, 32'(s_load_count), 4);
    checkOutput("full_overflow", 221, 32'(s_overflow), 0);
    checkOutput("full_run",      221, 32'(s_run), 1);
    smallStep(0, 0, 10'd0, 0, 1, 2'd3);
    checkOutput("full_read_data", 222, 32'(s_read_data), 32'(10'b1010000011));
    checkOutput("full_addr_err",  222, 32'(s_addr_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
